// File: rtl/rf_pkg.sv
// Shared definitions for the scoreboarded register file.
//   RF_DATA_W / RF_ADDR_W : default register width and address width
//   RF_NUM_REGS           : default register count (2**RF_ADDR_W)
//   addr_hit()            : address compare that never matches register 0
//                           when that register is hardwired to zero
package rf_pkg;

   localparam int RF_DATA_W   = 32;
   localparam int RF_ADDR_W   = 5;
   localparam int RF_NUM_REGS = 2 ** RF_ADDR_W;

   // True when a equals b and the address is not the hardwired zero register.
   // Callers cast their addresses to 32 bits so any ADDR_W up to 32 fits.
   function automatic logic addr_hit(input logic [31:0] a,
                                     input logic [31:0] b,
                                     input bit          zero_guard);
      return (a == b) && !(zero_guard && (a == 32'd0));
   endfunction

endpackage

// File: rtl/rf_sb_scoreboard.sv
// Pending-producer scoreboard for the register file.
//   clk, rst             : clock, synchronous active-high reset
//   iss, iss_addr        : mark iss_addr pending (new producer issued)
//   write, Rd_addr       : writeback retires the producer of Rd_addr
//   flush                : clear every pending bit
//   Rs_addr / Rt_addr    : lookup addresses for the two read ports
//   Rs_busy / Rt_busy    : lookup result, cleared when writeback forwards
//   pend_cnt             : registered count of pending registers
module rf_sb_scoreboard
   import rf_pkg::*;
#(
   parameter int ADDR_W   = RF_ADDR_W,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              iss,
   input  logic [ADDR_W-1:0] iss_addr,
   input  logic              write,
   input  logic [ADDR_W-1:0] Rd_addr,
   input  logic              flush,
   input  logic [ADDR_W-1:0] Rs_addr,
   input  logic [ADDR_W-1:0] Rt_addr,
   output logic              Rs_busy,
   output logic              Rt_busy,
   output logic [ADDR_W:0]   pend_cnt
);

   localparam int NUM_REGS = 2 ** ADDR_W;

   logic [NUM_REGS-1:0] pend;
   logic                set_p, clr_p, inc, dec;
   logic [ADDR_W:0]     cnt_next;

   always_comb begin
      // NOTE: every always_comb output gets a default before any branch so
      // no path leaves it unassigned, which would infer a latch.
      set_p    = iss && !(ZERO_REG && (iss_addr == '0));
      // A write to the address being issued this cycle does not clear it:
      // the new producer outranks the retiring one.
      clr_p    = write && !(ZERO_REG && (Rd_addr == '0))
                 && !(set_p && (iss_addr == Rd_addr));
      // Count only real transitions so the counter tracks popcount(pend).
      inc      = set_p && !pend[iss_addr];
      dec      = clr_p && pend[Rd_addr];
      cnt_next = pend_cnt;
      if (inc) cnt_next = cnt_next + (ADDR_W+1)'(1);
      if (dec) cnt_next = cnt_next - (ADDR_W+1)'(1);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst || flush) begin
         pend     <= '0;
         pend_cnt <= '0;
      end else begin
         if (set_p) pend[iss_addr] <= 1'b1;
         if (clr_p) pend[Rd_addr]  <= 1'b0;
         pend_cnt <= cnt_next;
      end
   end

   // A same-cycle writeback to the looked-up register forwards its data,
   // so the reader no longer has to wait on it.
   assign Rs_busy = pend[Rs_addr]
                    && !(ZERO_REG && (Rs_addr == '0))
                    && !(BYPASS && write && addr_hit(32'(Rd_addr), 32'(Rs_addr), ZERO_REG));
   assign Rt_busy = pend[Rt_addr]
                    && !(ZERO_REG && (Rt_addr == '0))
                    && !(BYPASS && write && addr_hit(32'(Rd_addr), 32'(Rt_addr), ZERO_REG));

endmodule

// File: rtl/rf_sb.sv
// Two-read / one-write register file with hardwired zero register, optional
// write-to-read bypass, synchronous clear and pending-producer scoreboard.
//   clk, rst                  : clock, synchronous active-high reset
//   Rs_addr/Rt_addr           : read addresses; Rs_data/Rt_data combinational
//   Rs_busy/Rt_busy           : register has an outstanding producer
//   write, Rd_addr, Rd_data   : writeback port
//   iss, iss_addr             : mark destination pending at issue
//   flush                     : clear all pending bits
//   pend_cnt                  : number of pending registers
module rf_sb
   import rf_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] Rs_addr,
   input  logic [ADDR_W-1:0] Rt_addr,
   output logic [DATA_W-1:0] Rs_data,
   output logic [DATA_W-1:0] Rt_data,
   output logic              Rs_busy,
   output logic              Rt_busy,
   input  logic              write,
   input  logic [ADDR_W-1:0] Rd_addr,
   input  logic [DATA_W-1:0] Rd_data,
   input  logic              iss,
   input  logic [ADDR_W-1:0] iss_addr,
   input  logic              flush,
   output logic [ADDR_W:0]   pend_cnt
);

   localparam int NUM_REGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              wr_en;

   assign wr_en = write && !(ZERO_REG && (Rd_addr == '0));

   always_ff @(posedge clk) begin
      // NOTE: the array is reset because software relies on every register
      // reading zero after reset; this keeps it in flops rather than RAM.
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[Rd_addr] <= Rd_data;
      end
   end

   // Priority: zero register, then bypass, then stored value.
   always_comb begin
      Rs_data = regs[Rs_addr];
      if (BYPASS && write && addr_hit(32'(Rd_addr), 32'(Rs_addr), ZERO_REG))
         Rs_data = Rd_data;
      if (ZERO_REG && (Rs_addr == '0))
         Rs_data = '0;

      Rt_data = regs[Rt_addr];
      if (BYPASS && write && addr_hit(32'(Rd_addr), 32'(Rt_addr), ZERO_REG))
         Rt_data = Rd_data;
      if (ZERO_REG && (Rt_addr == '0))
         Rt_data = '0;
   end

   rf_sb_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .iss      (iss),
      .iss_addr (iss_addr),
      .write    (write),
      .Rd_addr  (Rd_addr),
      .flush    (flush),
      .Rs_addr  (Rs_addr),
      .Rt_addr  (Rt_addr),
      .Rs_busy  (Rs_busy),
      .Rt_busy  (Rt_busy),
      .pend_cnt (pend_cnt)
   );

endmodule

// File: tb/tb_rf_sb.sv
// Directed bench for rf_sb: one instance with bypass, one without, sharing
// all inputs. Inputs change 1 time unit after the rising edge; outputs are
// sampled 1 unit after that, well clear of the next edge.
module tb_rf_sb;
   import rf_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  Rs_addr, Rt_addr, Rd_addr, iss_addr;
   logic [31:0] Rd_data;
   logic        write, iss, flush;

   logic [31:0] rs_data_b, rt_data_b, rs_data_n, rt_data_n;
   logic        rs_busy_b, rt_busy_b, rs_busy_n, rt_busy_n;
   logic [5:0]  pend_cnt_b, pend_cnt_n;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   rf_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_b (
      .clk(clk), .rst(rst),
      .Rs_addr(Rs_addr), .Rt_addr(Rt_addr),
      .Rs_data(rs_data_b), .Rt_data(rt_data_b),
      .Rs_busy(rs_busy_b), .Rt_busy(rt_busy_b),
      .write(write), .Rd_addr(Rd_addr), .Rd_data(Rd_data),
      .iss(iss), .iss_addr(iss_addr), .flush(flush),
      .pend_cnt(pend_cnt_b)
   );

   rf_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_n (
      .clk(clk), .rst(rst),
      .Rs_addr(Rs_addr), .Rt_addr(Rt_addr),
      .Rs_data(rs_data_n), .Rt_data(rt_data_n),
      .Rs_busy(rs_busy_n), .Rt_busy(rt_busy_n),
      .write(write), .Rd_addr(Rd_addr), .Rd_data(Rd_data),
      .iss(iss), .iss_addr(iss_addr), .flush(flush),
      .pend_cnt(pend_cnt_n)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one edge, then return control 1 unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      rst = 1'b0; write = 1'b0; iss = 1'b0; flush = 1'b0;
      Rd_addr = '0; Rd_data = '0; iss_addr = '0;
   endtask

   task automatic do_iss(input logic [4:0] a);
      iss = 1'b1; iss_addr = a;
      tick();
      iss = 1'b0;
   endtask

   initial begin
      quiet();
      Rs_addr = '0; Rt_addr = '0;

      // Reset, then sweep every address on both ports.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < RF_NUM_REGS; i++) begin
         Rs_addr = 5'(i);
         Rt_addr = 5'(31 - i);
         #1;
         check($sformatf("rst_rs_data[%0d]", i), rs_data_b, 0);
         check($sformatf("rst_rt_data[%0d]", i), rt_data_b, 0);
         check($sformatf("rst_busy[%0d]", i), {rs_busy_b, rt_busy_b}, 0);
      end
      check("rst_pend_cnt", pend_cnt_b, 0);

      // Plain write, read back next cycle on both ports.
      write = 1'b1; Rd_addr = 5; Rd_data = 32'hDEADBEEF;
      tick();
      quiet();
      Rs_addr = 5; Rt_addr = 5;
      #1;
      check("r5_rs", rs_data_b, 32'hDEADBEEF);
      check("r5_rt", rt_data_b, 32'hDEADBEEF);
      check("r5_rs_nobyp", rs_data_n, 32'hDEADBEEF);

      // Same-cycle write/read of R6: forwarded with bypass, stale without.
      write = 1'b1; Rd_addr = 6; Rd_data = 32'h12345678; Rs_addr = 6;
      #1;
      check("byp_r6", rs_data_b, 32'h12345678);
      check("nobyp_r6_old", rs_data_n, 32'h0);
      tick();
      quiet();
      #1;
      check("nobyp_r6_new", rs_data_n, 32'h12345678);

      // Zero register: write and issue are both dropped.
      write = 1'b1; Rd_addr = 0; Rd_data = 32'hFFFFFFFF;
      iss = 1'b1; iss_addr = 0; Rs_addr = 0;
      #1;
      check("r0_comb", rs_data_b, 0);
      tick();
      quiet();
      #1;
      check("r0_data", rs_data_b, 0);
      check("r0_busy", rs_busy_b, 0);
      check("r0_pend_cnt", pend_cnt_b, 0);

      // Issue R3 and R7, then iss+write R3 together, then write R7.
      do_iss(3);
      do_iss(7);
      Rs_addr = 3; Rt_addr = 7;
      #1;
      check("iss2_cnt", pend_cnt_b, 2);
      check("iss2_rs_busy", rs_busy_b, 1);
      check("iss2_rt_busy", rt_busy_b, 1);
      write = 1'b1; Rd_addr = 3; Rd_data = 32'h33; iss = 1'b1; iss_addr = 3;
      #1;
      check("wi3_busy_byp", rs_busy_b, 0);
      check("wi3_busy_nobyp", rs_busy_n, 1);
      tick();
      quiet();
      #1;
      check("wi3_busy", rs_busy_b, 1);
      check("wi3_cnt", pend_cnt_b, 2);
      check("wi3_data", rs_data_b, 32'h33);
      write = 1'b1; Rd_addr = 7; Rd_data = 32'h55;
      #1;
      check("w7_rt_comb_byp", rt_data_b, 32'h55);
      check("w7_rt_comb_nobyp", rt_data_n, 32'h0);
      check("w7_busy_nobyp", rt_busy_n, 1);
      tick();
      quiet();
      #1;
      check("w7_cnt", pend_cnt_b, 1);
      check("w7_rt_busy", rt_busy_b, 0);
      check("w7_rt_data", rt_data_b, 32'h55);

      // Re-issue a pending reg; write a non-pending reg; iss/write on
      // different addresses in one cycle (net zero).
      do_iss(3);
      check("reiss_cnt", pend_cnt_b, 1);
      write = 1'b1; Rd_addr = 10; Rd_data = 32'h10;
      tick();
      quiet();
      check("w10_cnt", pend_cnt_b, 1);
      write = 1'b1; Rd_addr = 3; Rd_data = 32'h3; iss = 1'b1; iss_addr = 12;
      tick();
      quiet();
      Rs_addr = 3; Rt_addr = 12;
      #1;
      check("net0_cnt", pend_cnt_b, 1);
      check("net0_rs_busy", rs_busy_b, 0);
      check("net0_rt_busy", rt_busy_b, 1);
      check("net0_cnt_nobyp", pend_cnt_n, 1);

      // Four pending, then flush with iss+write of R9.
      do_iss(1);
      do_iss(2);
      do_iss(4);
      check("four_cnt", pend_cnt_b, 4);
      flush = 1'b1; iss = 1'b1; iss_addr = 9;
      write = 1'b1; Rd_addr = 9; Rd_data = 32'hA5;
      tick();
      quiet();
      Rs_addr = 9; Rt_addr = 12;
      #1;
      check("flush_cnt", pend_cnt_b, 0);
      check("flush_r9_busy", rs_busy_b, 0);
      check("flush_r12_busy", rt_busy_b, 0);
      check("flush_r9_data", rs_data_b, 32'hA5);

      // Issue every address: count saturates at 31 (R0 never pends).
      for (int i = 0; i < RF_NUM_REGS; i++) do_iss(5'(i));
      check("full_cnt", pend_cnt_b, 31);
      do_iss(31);
      check("full_reiss_cnt", pend_cnt_b, 31);
      flush = 1'b1;
      tick();
      quiet();
      check("full_flush_cnt", pend_cnt_b, 0);

      // Reset overrides a concurrent write with registers pending.
      do_iss(1);
      do_iss(2);
      do_iss(4);
      check("pre_rst_cnt", pend_cnt_b, 3);
      rst = 1'b1; write = 1'b1; Rd_addr = 4; Rd_data = 32'h77;
      iss = 1'b1; iss_addr = 8;
      tick();
      quiet();
      Rs_addr = 4; Rt_addr = 1;
      #1;
      check("rst2_r4", rs_data_b, 0);
      check("rst2_cnt", pend_cnt_b, 0);
      check("rst2_busy", {rs_busy_b, rt_busy_b}, 0);
      Rs_addr = 5; Rt_addr = 9;
      #1;
      check("rst2_r5", rs_data_b, 0);
      check("rst2_r9", rt_data_b, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/rf_sb.md
Name: rf_sb

Overview:
- Parametrised successor to the 2-read/1-write CPU register file, for the pipelined datapath.
- Adds hardwired zero register, optional write-to-read bypass, synchronous clear, and a per-register pending scoreboard.
- Decode reads operands and hazard status here; writeback writes here; issue marks destinations pending.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth NUM_REGS = 2**ADDR_W
- ZERO_REG, 1, 1 = R[0] reads 0, ignores writes, is never pending
- BYPASS, 1, 1 = same-cycle write data/pending-clear forwarded to read ports

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- Rs_addr  in  ADDR_W  read port A address
- Rt_addr  in  ADDR_W  read port B address
- Rs_data  out  DATA_W  read port A data
- Rt_data  out  DATA_W  read port B data
- Rs_busy  out  1  port A register has an outstanding producer
- Rt_busy  out  1  port B register has an outstanding producer
- write  in  1  writeback enable
- Rd_addr  in  ADDR_W  writeback address
- Rd_data  in  DATA_W  writeback data
- iss  in  1  issue: mark iss_addr pending
- iss_addr  in  ADDR_W  destination of issued instruction
- flush  in  1  clear all pending bits
- pend_cnt  out  ADDR_W+1  number of pending registers

Behaviour:
- Reset: all R[i] = 0, all pending = 0, pend_cnt = 0; outputs read 0/not busy the cycle after rst. rst overrides write/iss/flush in the same cycle.
- Reads are combinational, zero-latency.
  - Base read: Rs_data = R[Rs_addr].
  - If BYPASS and write and Rd_addr == Rs_addr (and not the zero reg), Rs_data = Rd_data. Same rule for Rt.
  - If ZERO_REG and addr == 0, data = 0 regardless.
- Write: on posedge with write = 1, R[Rd_addr] <= Rd_data. Dropped when ZERO_REG and Rd_addr == 0. write = 0 leaves all registers unchanged.
- Pending bit p[i], updated on posedge in priority order:
  1. flush: all p = 0; iss and the write-clear are ignored for pending. The register write itself still happens.
  2. iss and write on the same address: p = 1. The new producer wins over the retiring one.
  3. iss: p[iss_addr] = 1.
  4. write: p[Rd_addr] = 0.
  - iss and write on different addresses both take effect.
  - iss to an already-pending register: stays 1, no count change.
  - write to a non-pending register: clears nothing, no count change.
  - iss or write to register 0 with ZERO_REG: no pending effect.
- Busy: Rs_busy = p[Rs_addr]. If BYPASS and write and Rd_addr == Rs_addr, Rs_busy = 0 (data is forwarded). Same rule for Rt. Register 0 with ZERO_REG is never busy.
- pend_cnt:
  - registered, equal to popcount(p) after each edge;
  - maintained incrementally: +1 on a 0→1 transition, −1 on a 1→0 transition, net 0 when both happen on different addresses;
  - flush sets it to 0;
  - no wrap: maximum is NUM_REGS − ZERO_REG.

Decomposition:
- Shared package rf_pkg:
  - default widths DATA_W / ADDR_W;
  - a localparam for NUM_REGS;
  - a function for address-match-with-zero-guard, reused by both read ports.
- One natural sub-module: rf_sb_scoreboard (pending vector, priority update, pend_cnt, busy lookup). Data array and bypass mux stay in the top.

Test Plan:
- rst = 1 one cycle, then read all 32 addresses -> every Rs_data/Rt_data = 0, busy = 0, pend_cnt = 0.
- write R5 = 0xDEADBEEF; next cycle Rs_addr = Rt_addr = 5 -> both read 0xDEADBEEF. Same-cycle write R6 = 0x12345678 with Rs_addr = 6 -> Rs_data = 0x12345678 combinationally (BYPASS = 1); old value with BYPASS = 0.
- write R0 = 0xFFFFFFFF and iss R0 -> Rs_addr = 0 reads 0, Rs_busy = 0, pend_cnt = 0.
- iss R3 and iss R7 on consecutive cycles -> pend_cnt = 2, Rs_busy (addr 3) = 1. Then write R3 with iss R3 in the same cycle -> R3 still pending, pend_cnt = 2. Then write R7 = 0x55 alone -> pend_cnt = 1, Rt_busy (addr 7) = 0.
- 4 pending regs, flush with iss R9 and write R9 = 0xA5 in the same cycle -> pend_cnt = 0, R9 not busy, R9 reads 0xA5.
- rst asserted while 3 regs pending and write R4 = 0x77 active -> next cycle R4 = 0, pend_cnt = 0, all busy = 0.
